// File: rtl/pkg_globals.sv
// Shared types and constants for the compute-unit AXI master engines.
package pkg_globals;

    localparam int unsigned M_AXI_BOUNDARY_BYTES = 4096;
    localparam int unsigned M_AXI_BEAT_BYTES     = 64;

    typedef enum logic [4:0] {
        RESET     = 5'b00001,
        READY     = 5'b00010,
        CMD_TRANS = 5'b00100,
        PEND      = 5'b01000,
        DONE      = 5'b10000
    } cu_engine_m_axi_state;

endpackage

// File: rtl/cu_engine_m_axi_read_cmd.sv
// AXI4 read-command engine: splits a beat-count transfer into 4 KB-safe bursts,
// bounds bursts in flight, and passes read data straight through to the consumer.
module cu_engine_m_axi_read_cmd
    import pkg_globals::*;
#(
    parameter int unsigned M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned M_AXI_DATA_WIDTH = 512,
    parameter int unsigned MAX_BURST_BEATS  = 64,
    parameter int unsigned MAX_OUTSTANDING  = 8
) (
    input  logic                        ap_clk,
    input  logic                        areset,
    input  logic                        cmd_start,
    input  logic [M_AXI_ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [31:0]                 cmd_length_beats,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    output logic [M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                  m_axi_arlen,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    input  logic [M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                        m_axi_rlast,
    input  logic [1:0]                  m_axi_rresp,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [M_AXI_DATA_WIDTH-1:0] out_data,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output cu_engine_m_axi_state        state
);

    localparam int unsigned OutW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned BeatShift = $clog2(M_AXI_BEAT_BYTES);
    localparam int unsigned PageMsb   = $clog2(M_AXI_BOUNDARY_BYTES) - 1;
    localparam int unsigned PageBeats = M_AXI_BOUNDARY_BYTES / M_AXI_BEAT_BYTES;
    localparam logic [OutW-1:0] OutMax = OutW'(MAX_OUTSTANDING);

    // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page.
    function automatic logic [31:0] burst_beats(input logic [31:0] remaining,
                                                input logic [PageMsb-BeatShift:0] page_idx);
        logic [31:0] beats;
        logic [31:0] page_left;
        page_left = PageBeats - 32'(page_idx);
        beats     = remaining;
        if (beats > MAX_BURST_BEATS) beats = MAX_BURST_BEATS;
        if (beats > page_left) beats = page_left;
        return beats;
    endfunction

    cu_engine_m_axi_state        state_q, state_d;
    logic [M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                 length_q, length_d;
    logic [31:0]                 remaining_q, remaining_d;
    logic [31:0]                 beats_rcvd_q, beats_rcvd_d;
    logic [OutW-1:0]             outstanding_q, outstanding_d;
    logic                        error_q, error_d;

    logic [31:0] burst;
    logic        active;
    logic        ar_valid;
    logic        ar_hs;
    logic        r_hs;
    logic        r_last_hs;

    assign burst     = burst_beats(remaining_q, addr_q[PageMsb:BeatShift]);
    assign active    = (state_q == CMD_TRANS) || (state_q == PEND);
    assign ar_valid  = (state_q == CMD_TRANS) && (remaining_q != '0) && (outstanding_q != OutMax);
    assign ar_hs     = ar_valid && m_axi_arready;
    // R beats only count while a transfer is live, so stragglers after reset are ignored.
    assign r_hs      = active && m_axi_rvalid && out_ready;
    assign r_last_hs = r_hs && m_axi_rlast;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        length_d      = length_q;
        remaining_d   = remaining_q;
        beats_rcvd_d  = beats_rcvd_q;
        outstanding_d = outstanding_q;
        error_d       = error_q;

        unique case (state_q)
            RESET: state_d = READY;
            READY: begin
                if (cmd_start) begin
                    addr_d        = cmd_base_addr;
                    length_d      = cmd_length_beats;
                    remaining_d   = cmd_length_beats;
                    beats_rcvd_d  = '0;
                    outstanding_d = '0;
                    error_d       = 1'b0;
                    state_d       = (cmd_length_beats == '0) ? DONE : CMD_TRANS;
                end
            end
            CMD_TRANS: begin
                if (ar_hs) begin
                    addr_d      = addr_q + (M_AXI_ADDR_WIDTH'(burst) << BeatShift);
                    remaining_d = remaining_q - burst;
                    if (remaining_d == '0) state_d = PEND;
                end
            end
            PEND: begin
                if ((outstanding_q == '0) && (beats_rcvd_q == length_q)) state_d = DONE;
            end
            DONE: state_d = READY;
            default: state_d = RESET;
        endcase

        if (r_hs) begin
            if (beats_rcvd_q != '1) beats_rcvd_d = beats_rcvd_q + 32'd1;
            if (m_axi_rresp != 2'b00) error_d = 1'b1;
        end

        if (ar_hs && !r_last_hs) begin
            outstanding_d = outstanding_q + OutW'(1);
        end else if (!ar_hs && r_last_hs && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OutW'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q       <= RESET;
            addr_q        <= '0;
            length_q      <= '0;
            remaining_q   <= '0;
            beats_rcvd_q  <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            length_q      <= length_d;
            remaining_q   <= remaining_d;
            beats_rcvd_q  <= beats_rcvd_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

    assign m_axi_arvalid = ar_valid;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(burst - 32'd1);
    assign m_axi_rready  = out_ready;
    assign out_valid     = m_axi_rvalid;
    assign out_data      = m_axi_rdata;
    assign busy          = active;
    assign done          = (state_q == DONE);
    assign error         = error_q;
    assign state         = state_q;

endmodule

// File: tb/tb_cu_engine_m_axi_read_cmd.sv
// Randomized bench for cu_engine_m_axi_read_cmd with an AXI slave model and a burst-plan reference.
module tb_cu_engine_m_axi_read_cmd;
    import pkg_globals::*;

    localparam int unsigned AW       = 64;
    localparam int unsigned DW       = 512;
    localparam int unsigned MaxOut   = 8;
    localparam int unsigned MaxBurst = 64;

    logic                 ap_clk = 1'b0;
    logic                 areset = 1'b1;
    logic                 cmd_start = 1'b0;
    logic [AW-1:0]        cmd_base_addr = '0;
    logic [31:0]          cmd_length_beats = '0;
    logic                 m_axi_arvalid;
    logic                 m_axi_arready = 1'b0;
    logic [AW-1:0]        m_axi_araddr;
    logic [7:0]           m_axi_arlen;
    logic                 m_axi_rvalid = 1'b0;
    logic                 m_axi_rready;
    logic [DW-1:0]        m_axi_rdata = '0;
    logic                 m_axi_rlast = 1'b0;
    logic [1:0]           m_axi_rresp = 2'b00;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DW-1:0]        out_data;
    logic                 busy;
    logic                 done;
    logic                 error;
    cu_engine_m_axi_state state;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr[$];
    int unsigned   exp_len[$];

    cu_engine_m_axi_read_cmd #(
        .M_AXI_ADDR_WIDTH(AW),
        .M_AXI_DATA_WIDTH(DW),
        .MAX_BURST_BEATS (MaxBurst),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .ap_clk          (ap_clk),
        .areset          (areset),
        .cmd_start       (cmd_start),
        .cmd_base_addr   (cmd_base_addr),
        .cmd_length_beats(cmd_length_beats),
        .m_axi_arvalid   (m_axi_arvalid),
        .m_axi_arready   (m_axi_arready),
        .m_axi_araddr    (m_axi_araddr),
        .m_axi_arlen     (m_axi_arlen),
        .m_axi_rvalid    (m_axi_rvalid),
        .m_axi_rready    (m_axi_rready),
        .m_axi_rdata     (m_axi_rdata),
        .m_axi_rlast     (m_axi_rlast),
        .m_axi_rresp     (m_axi_rresp),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .state           (state)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference burst plan: greedy split, never past the burst cap or a 4 KB page end.
    task automatic plan(input logic [AW-1:0] base, input int unsigned len);
        logic [AW-1:0] a;
        int unsigned   rem;
        int unsigned   b;
        int unsigned   room;
        a = base;
        rem = len;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            room = 64 - ((32'(a[11:0])) / 64);
            b = rem;
            if (b > MaxBurst) b = MaxBurst;
            if (b > room) b = room;
            exp_addr.push_back(a);
            exp_len.push_back(b);
            a = a + AW'(b * 64);
            rem = rem - b;
        end
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input int unsigned len,
                            input int unsigned ar_pct, input int unsigned r_pct,
                            input int unsigned or_pct, input int unsigned ar_hold,
                            input int unsigned r_hold, input int err_beat);
        int unsigned          nb;
        int unsigned          ar_idx = 0;
        int unsigned          beats_out = 0;
        int unsigned          model_out = 0;
        int unsigned          r_beat = 0;
        int                   last_evt = -2;
        bit                   exp_err = 1'b0;
        bit                   r_stall = 1'b0;
        bit                   finished = 1'b0;
        bit                   exp_done;
        int unsigned          rq[$];
        cu_engine_m_axi_state exp_st;

        plan(base, len);
        nb = exp_addr.size();
        @(negedge ap_clk);
        cmd_start = 1'b1;
        cmd_base_addr = base;
        cmd_length_beats = len;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
        out_ready = 1'b0;
        #1 chk("ready_before_start", state, READY);

        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge ap_clk);
            // Stray starts during a transfer must be ignored.
            cmd_start = ($urandom_range(15) == 0);
            cmd_base_addr = {$urandom, $urandom};
            cmd_length_beats = $urandom;
            m_axi_arready = (cyc >= int'(ar_hold)) && ($urandom_range(99) < ar_pct);
            if (!r_stall) begin
                if (rq.size() > 0 && cyc >= int'(r_hold) && $urandom_range(99) < r_pct) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata = {16{$urandom}};
                    m_axi_rlast = (r_beat == rq[0] - 1);
                    m_axi_rresp = (int'(beats_out) == err_beat) ? 2'd2 : 2'd0;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast = 1'b0;
                    m_axi_rresp = 2'b00;
                end
            end
            out_ready = ($urandom_range(99) < or_pct);
            #1;
            exp_done = (ar_idx == nb) && (beats_out == len) && (cyc == last_evt + 2);
            exp_st = exp_done ? DONE : ((ar_idx < nb) ? CMD_TRANS : PEND);
            chk("state", state, exp_st);
            chk("busy_done", {busy, done}, {!exp_done, exp_done});
            chk("error", error, exp_err);
            chk("passthru", {out_valid, m_axi_rready, out_data},
                {m_axi_rvalid, out_ready, m_axi_rdata});
            if (exp_done) begin
                chk("arvalid_in_done", m_axi_arvalid, 1'b0);
                finished = 1'b1;
            end else begin
                chk("arvalid", m_axi_arvalid, (ar_idx < nb) && (model_out < MaxOut));
                if (m_axi_arvalid && ar_idx < nb) begin
                    chk("ar_addr_len", {m_axi_araddr, m_axi_arlen},
                        {exp_addr[ar_idx], 8'(exp_len[ar_idx] - 1)});
                    if (m_axi_arready) begin
                        rq.push_back(exp_len[ar_idx]);
                        ar_idx++;
                        model_out++;
                        last_evt = cyc;
                    end
                end
                if (m_axi_rvalid && out_ready) begin
                    if (m_axi_rresp != 2'b00) exp_err = 1'b1;
                    beats_out++;
                    last_evt = cyc;
                    if (m_axi_rlast) begin
                        void'(rq.pop_front());
                        r_beat = 0;
                        model_out--;
                    end else begin
                        r_beat++;
                    end
                end
                r_stall = m_axi_rvalid && !out_ready;
            end
        end
        if (!finished) chk("timeout", 1'b0, 1'b1);

        @(negedge ap_clk);
        cmd_start = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;
        out_ready = 1'b0;
        #1 chk("after_done", {state, done, busy, error}, {READY, 1'b0, 1'b0, exp_err});
    endtask

    initial begin
        areset = 1'b1;
        repeat (3) @(negedge ap_clk);
        #1 chk("reset_state", {state, m_axi_arvalid, busy, done, error}, {RESET, 4'b0000});
        areset = 1'b0;
        @(negedge ap_clk);
        #1 chk("ready_after_reset", state, READY);

        run_xfer(64'h0, 128, 100, 100, 100, 0, 0, -1);
        run_xfer(64'hFC0, 4, 100, 100, 100, 0, 0, -1);
        run_xfer(64'h2000, 640, 100, 100, 100, 0, 30, -1);
        run_xfer(64'h40, 20, 100, 100, 100, 5, 0, -1);
        run_xfer(64'h8000, 10, 100, 100, 100, 0, 0, 2);
        run_xfer(64'h3FC0, 70, 70, 80, 90, 0, 0, -1);

        // Reset while waiting for data: the transfer is dropped and late R beats do nothing.
        @(negedge ap_clk);
        cmd_start = 1'b1;
        cmd_base_addr = 64'h10000;
        cmd_length_beats = 128;
        m_axi_arready = 1'b1;
        m_axi_rvalid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            cmd_start = 1'b0;
            #1;
            if (state === PEND) break;
        end
        chk("pend_reached", state, PEND);
        @(negedge ap_clk);
        areset = 1'b1;
        m_axi_rvalid = 1'b1;
        m_axi_rlast = 1'b1;
        m_axi_rresp = 2'd2;
        @(negedge ap_clk);
        #1 chk("reset_in_pend", {state, m_axi_arvalid, busy, done, error}, {RESET, 4'b0000});
        areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ap_clk);
            #1 chk("post_reset_idle", {state, m_axi_arvalid, busy, done, error},
                   {READY, 4'b0000});
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0;
        m_axi_rresp = 2'b00;

        run_xfer(64'h5000, 0, 100, 100, 100, 0, 0, -1);

        for (int n = 0; n < 8; n++) begin
            run_xfer({16'h0, $urandom, 10'($urandom_range(0, 1023)), 6'b0},
                     $urandom_range(1, 400), $urandom_range(50, 100),
                     $urandom_range(50, 100), $urandom_range(50, 100),
                     $urandom_range(0, 3), $urandom_range(0, 20),
                     ($urandom_range(3) == 0) ? int'($urandom_range(0, 50)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cu_engine_m_axi_read_cmd.md
CU_ENGINE_M_AXI_READ_CMD -- requirements
Module: cu_engine_m_axi_read_cmd

Interface
REQ-001 SHALL have parameter M_AXI_ADDR_WIDTH, default 64: byte address width.
REQ-002 SHALL have parameter M_AXI_DATA_WIDTH, default 512: beat width in bits (64 B per beat).
REQ-003 SHALL have parameter MAX_BURST_BEATS, default 64: the largest ARLEN+1 the block issues.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8: the most bursts in flight at once.
REQ-005 SHALL have port ap_clk, input, 1 bit: the only clock; all logic is rising-edge.
REQ-006 SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port cmd_start, input, 1 bit: one-cycle request to start a transfer; accepted only in READY.
REQ-008 SHALL have port cmd_base_addr, input, M_AXI_ADDR_WIDTH bits: start byte address, 64 B aligned.
REQ-009 SHALL have port cmd_length_beats, input, 32 bits: total number of beats to read.
REQ-010 SHALL have ports m_axi_arvalid (output, 1), m_axi_arready (input, 1), m_axi_araddr (output, M_AXI_ADDR_WIDTH) and m_axi_arlen (output, 8): AXI4 read-address channel.
REQ-011 SHALL have ports m_axi_rvalid (input, 1), m_axi_rready (output, 1), m_axi_rdata (input, M_AXI_DATA_WIDTH), m_axi_rlast (input, 1) and m_axi_rresp (input, 2): AXI4 read-data channel.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, M_AXI_DATA_WIDTH): the read-data stream to the consumer.
REQ-013 SHALL have ports busy (output, 1), done (output, 1), error (output, 1) and state (output, cu_engine_m_axi_state): transfer status.

Function
REQ-014 SHALL implement the one-hot states RESET, READY, CMD_TRANS, PEND and DONE of cu_engine_m_axi_state, and drive state with the current state.
REQ-015 SHALL move RESET->READY on the first cycle with areset low.
REQ-016 SHALL, in READY when cmd_start=1, latch address and length, clear the beat and outstanding counters and error, then go to CMD_TRANS, or directly to DONE if length=0.
REQ-017 SHALL compute each burst as min(remaining_cmd_beats, MAX_BURST_BEATS, 64 - araddr[11:6]) beats, so that no burst crosses a 4 KB boundary; m_axi_arlen = beats-1.
REQ-018 SHALL hold m_axi_araddr and m_axi_arlen stable while m_axi_arvalid=1 and m_axi_arready=0; arvalid SHALL NOT drop before its handshake.
REQ-019 SHALL, on each AR handshake, advance the address by beats*64, subtract beats from the remaining count and increment outstanding.
REQ-020 SHALL hold m_axi_arvalid low while outstanding == MAX_OUTSTANDING.
REQ-021 SHALL decrement outstanding on an R handshake with m_axi_rlast=1; a simultaneous AR handshake and R-last handshake leaves outstanding unchanged.
REQ-022 SHALL move CMD_TRANS->PEND in the cycle after the last AR handshake (remaining=0).
REQ-023 SHALL move PEND->DONE when outstanding=0 and beats_received == length.
REQ-024 SHALL spend exactly one cycle in DONE with done=1, then return to READY.
REQ-025 SHALL pass the R channel through combinationally: out_valid=m_axi_rvalid, out_data=m_axi_rdata, m_axi_rready=out_ready, with zero latency and no buffering.
REQ-026 SHALL increment beats_received on every R handshake.
REQ-027 SHALL set error sticky when m_axi_rresp != 0 on an R handshake, and clear it only on the next accepted cmd_start.
REQ-028 SHALL assert busy=1 in CMD_TRANS and PEND only.
REQ-029 SHALL ignore cmd_start outside READY.
REQ-030 SHALL NOT wrap its counters: they are 32 bits wide, and the outstanding counter is clog2(MAX_OUTSTANDING+1) bits wide.

Reset
REQ-031 SHALL, on areset=1 at a clock edge, enter RESET and drive arvalid=0, done=0, busy=0 and error=0, with the address and all counters cleared.
REQ-032 SHALL, on a reset during a transfer, abandon it without completing any pending AR handshake; in-flight R beats arriving after reset SHALL NOT alter state.

Structure
REQ-033 SHALL take cu_engine_m_axi_state from PKG_GLOBALS.
REQ-034 SHALL place new constants M_AXI_BOUNDARY_BYTES=4096 and M_AXI_BEAT_BYTES=64 in PKG_GLOBALS.
REQ-035 SHALL be a single module with no sub-modules; the burst-length computation is a local function.

Verification
REQ-036 SHALL cover: base 0x0, length 128, arready and rvalid always 1 -> two bursts with arlen=63 at 0x0 and 0x1000, 128 beats out, one done pulse, error=0.
REQ-037 SHALL cover: base 0xFC0, length 4 -> bursts of arlen=0 at 0xFC0 and arlen=2 at 0x1000.
REQ-038 SHALL cover: length 640 with R withheld -> arvalid stalls after 8 bursts, and resumes only after an rlast handshake.
REQ-039 SHALL cover: arready held low for 5 cycles -> araddr and arlen stable throughout, arvalid held high.
REQ-040 SHALL cover: rresp=2 on beat 3 of 10 -> error=1 through DONE and READY, cleared on the next cmd_start.
REQ-041 SHALL cover: areset asserted in PEND -> state=RESET next cycle, arvalid=0, busy=0, no done pulse; length=0 start -> done one cycle after start, no AR issued.
